ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
Downstream stage of the PS/2 byte receiver. Consumes received bytes (data_valid level plus 8-bit byte, produced in the SCL domain) and decodes scan code set 2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events. Presents each event through a one-entry valid/ready output register. Tracks shift state and, optionally, translates codes to ASCII for the display/UART path.

Parameters:
SYNC_STAGES, 2, number of flops synchronising data_valid_in into clk (min 2)
PAUSE_SKIP, 7, bytes discarded after an E1 prefix

Ports:
clk  input  1  system clock
RST  input  1  synchronous, active-low reset
data_valid_in  input  1  byte-valid level from receiver (SCL domain, may stay high many clk cycles)
data_in  input  8  received byte; stable while data_valid_in high
ev_valid  output  1  event register holds an unconsumed event
ev_ready  input  1  consumer accepts event when ev_valid && ev_ready
ev_code  output  8  scan code (prefixes stripped)
ev_ext  output  1  event was E0-prefixed
ev_release  output  1  event was F0 break (key up)
ev_ascii  output  8  ASCII of event (0x00 if none)
shift_held  output  1  left or right shift currently pressed
overflow  output  1  sticky: an event was dropped

Behaviour:
- Reset: clk and RST are already decided as above; RST is synchronous, active-low. On RST low at posedge clk, all outputs are 0, the sync chain is cleared, state goes to IDLE, and the skip counter is 0. Reset mid-sequence discards any partial prefix.
- Input capture:
  - data_valid_in passes through SYNC_STAGES flops, then a rising-edge detect.
  - On the detected edge, data_in is registered into byte_r and byte_stb pulses for 1 cycle.
  - Latency from data_valid_in rise to byte_stb is SYNC_STAGES+1 clk.
  - A level held high produces exactly one strobe.
- State machine (advances only on byte_stb):
  - IDLE:
    - E0 -> EXT.
    - F0 -> REL.
    - E1 -> SKIP, with counter loaded to PAUSE_SKIP.
    - AA, FA, FE, EE, 00, FF -> IDLE, no event.
    - Any other byte -> emit (ext=0, rel=0), stay in IDLE.
  - EXT:
    - F0 -> EXT_REL.
    - E0 -> EXT.
    - 12 -> IDLE, no event (fake shift).
    - Any other byte -> emit (ext=1, rel=0), go to IDLE.
  - REL: any byte -> emit (ext=0, rel=1), go to IDLE.
  - EXT_REL:
    - 12 -> IDLE, no event.
    - Any other byte -> emit (ext=1, rel=1), go to IDLE.
  - SKIP: decrement the counter on each byte; at 0 -> IDLE. No events; shift state untouched.
- Emit:
  - The event register loads 1 cycle after byte_stb (ev_valid rises SYNC_STAGES+2 clk after the input edge).
  - ev_code, ev_ext, ev_release and ev_ascii are loaded together and held constant while ev_valid=1.
- Handshake:
  - ev_valid clears on the cycle after ev_valid && ev_ready.
  - Emit in the same cycle as an accept: the new event loads and ev_valid stays 1.
  - Emit while ev_valid && !ev_ready: the new event is dropped, the old one is retained, and overflow is set. overflow stays 1 until RST.
- Shift tracking:
  - Non-extended code 12 or 59 with rel=0 sets the respective held bit; with rel=1 it clears it.
  - shift_held = OR of the two bits.
  - Updates on the same cycle as the emit; shift events are still emitted.
- Typematic repeat (repeated make codes) produces one event per make; no filtering.

Optional Feature:
- Macro: PS2_ASCII_EN.
- Defined:
  - ev_ascii is produced by a combinational set-2 table applied at emit, for non-extended make events only.
  - Letters: 1C=a, 32=b, 21=c, 23=d, 24=e, 2B=f, 34=g, 33=h, 43=i, 3B=j, 42=k, 4B=l, 3A=m, 31=n, 44=o, 4D=p, 15=q, 2D=r, 1B=s, 2C=t, 3C=u, 2A=v, 1D=w, 22=x, 35=y, 1A=z. These are uppercase when shift_held (the value before the current byte's update).
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - Others: 29=0x20, 5A=0x0D, 66=0x08.
  - Anything else, release events and extended events give 0x00.
- Undefined: ev_ascii is tied to 0x00 and no table logic is synthesised.

Test Plan:
- Bytes 1C, then F0 1C, ev_ready=1 -> events {1C, ext0, rel0, ascii 0x61} then {1C, ext0, rel1, ascii 0x00}; ev_valid rises 4 clk after the first data_valid_in edge (SYNC_STAGES=2).
- Bytes 12, 1C, F0 12, 1C -> shift_held 1 after the first byte; ascii 0x41 then 0x61; shift_held 0 after F0 12.
- Bytes E0 75, then E0 F0 75 -> {75, ext1, rel0}, {75, ext1, rel1}; E0 12 and E0 F0 12 produce no events.
- E1 14 77 E1 F0 14 F0 77, then 29 -> no events for the 8-byte pause sequence; then {29, ascii 0x20}.
- ev_ready=0 with bytes 1C and 32 -> ev_code stays 1C; overflow=1. Raise ev_ready: one accept, then ev_valid=0. data_valid_in held high 500 clk -> exactly one event.
- Send E0, assert RST low for 1 cycle, then send 1C -> {1C, ext0}; all outputs 0 during reset; overflow cleared.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan code set 2 decoder: folds E0/F0/E1 prefix sequences into single key events
// behind a one-entry valid/ready register. Define PS2_ASCII_EN to enable the ASCII table.
module ps2_scancode_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PAUSE_SKIP  = 7
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       data_valid_in,
  input  logic [7:0] data_in,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic [7:0] ev_ascii,
  output logic       shift_held,
  output logic       overflow
);

  localparam int CW = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP + 1) : 1;

  typedef enum logic [2:0] {IDLE, EXT, REL, EXT_REL, SKIP} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   dv_prev_reg;
  logic                   byte_stb_reg;
  logic [7:0]             byte_reg;
  logic                   dv_rise;

  state_t                 state_reg;
  logic [CW-1:0]          skip_cnt_reg;
  logic                   ev_valid_reg;
  logic [7:0]             ev_code_reg;
  logic                   ev_ext_reg;
  logic                   ev_release_reg;
  logic                   shift_l_reg;
  logic                   shift_r_reg;
  logic                   overflow_reg;

  logic                   emit;
  logic                   emit_ext;
  logic                   emit_rel;

  // data_valid_in lives in the receiver's domain, so it is synchronised before edge detection
  always_ff @(posedge clk) begin
    if (!RST) begin
      sync_reg     <= '0;
      dv_prev_reg  <= 1'b0;
      byte_stb_reg <= 1'b0;
      byte_reg     <= 8'h00;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], data_valid_in};
      dv_prev_reg  <= sync_reg[SYNC_STAGES-1];
      byte_stb_reg <= dv_rise;
      if (dv_rise)
        byte_reg <= data_in;
    end
  end

  assign dv_rise = sync_reg[SYNC_STAGES-1] & ~dv_prev_reg;

  always_comb begin
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_rel = 1'b0;
    if (byte_stb_reg) begin
      case (state_reg)
        IDLE: begin
          case (byte_reg)
            8'hE0, 8'hF0, 8'hE1,
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: emit = 1'b0;
            default:                                  emit = 1'b1;
          endcase
        end
        EXT: begin
          emit     = (byte_reg != 8'hF0) && (byte_reg != 8'hE0) && (byte_reg != 8'h12);
          emit_ext = 1'b1;
        end
        REL: begin
          emit     = 1'b1;
          emit_rel = 1'b1;
        end
        EXT_REL: begin
          emit     = (byte_reg != 8'h12);
          emit_ext = 1'b1;
          emit_rel = 1'b1;
        end
        default: emit = 1'b0;
      endcase
    end
  end

`ifdef PS2_ASCII_EN
  logic [7:0] ev_ascii_reg;
  logic [7:0] emit_ascii;

  function automatic logic [7:0] set2_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] letter;
    letter = 8'h00;
    case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";  8'h23: letter = "d";
      8'h24: letter = "e";  8'h2B: letter = "f";  8'h34: letter = "g";  8'h33: letter = "h";
      8'h43: letter = "i";  8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";  8'h4D: letter = "p";
      8'h15: letter = "q";  8'h2D: letter = "r";  8'h1B: letter = "s";  8'h2C: letter = "t";
      8'h3C: letter = "u";  8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
    if (letter != 8'h00)
      return upper ? (letter - 8'h20) : letter;
    case (code)
      8'h45: return "0";  8'h16: return "1";  8'h1E: return "2";  8'h26: return "3";
      8'h25: return "4";  8'h2E: return "5";  8'h36: return "6";  8'h3D: return "7";
      8'h3E: return "8";  8'h46: return "9";
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  // Shift state here is the value before this byte's own update
  assign emit_ascii = (!emit_ext && !emit_rel) ? set2_ascii(byte_reg, shift_l_reg | shift_r_reg)
                                               : 8'h00;
  assign ev_ascii   = ev_ascii_reg;
`else
  assign ev_ascii   = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_reg      <= IDLE;
      skip_cnt_reg   <= '0;
      ev_valid_reg   <= 1'b0;
      ev_code_reg    <= 8'h00;
      ev_ext_reg     <= 1'b0;
      ev_release_reg <= 1'b0;
      shift_l_reg    <= 1'b0;
      shift_r_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
`ifdef PS2_ASCII_EN
      ev_ascii_reg   <= 8'h00;
`endif
    end else begin
      if (byte_stb_reg) begin
        case (state_reg)
          IDLE: begin
            case (byte_reg)
              8'hE0: state_reg <= EXT;
              8'hF0: state_reg <= REL;
              8'hE1: begin
                state_reg    <= (PAUSE_SKIP == 0) ? IDLE : SKIP;
                skip_cnt_reg <= CW'(PAUSE_SKIP);
              end
              default: state_reg <= IDLE;
            endcase
          end
          EXT: begin
            if (byte_reg == 8'hF0)
              state_reg <= EXT_REL;
            else if (byte_reg == 8'hE0)
              state_reg <= EXT;
            else
              state_reg <= IDLE;
          end
          SKIP: begin
            if (skip_cnt_reg <= CW'(1)) begin
              skip_cnt_reg <= '0;
              state_reg    <= IDLE;
            end else begin
              skip_cnt_reg <= skip_cnt_reg - CW'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end

      // A full, unaccepted register keeps its event; the newcomer is lost and flagged
      if (emit) begin
        if (!ev_valid_reg || ev_ready) begin
          ev_valid_reg   <= 1'b1;
          ev_code_reg    <= byte_reg;
          ev_ext_reg     <= emit_ext;
          ev_release_reg <= emit_rel;
`ifdef PS2_ASCII_EN
          ev_ascii_reg   <= emit_ascii;
`endif
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (ev_valid_reg && ev_ready) begin
        ev_valid_reg <= 1'b0;
      end

      if (emit && !emit_ext) begin
        if (byte_reg == 8'h12)
          shift_l_reg <= !emit_rel;
        if (byte_reg == 8'h59)
          shift_r_reg <= !emit_rel;
      end
    end
  end

  assign ev_valid   = ev_valid_reg;
  assign ev_code    = ev_code_reg;
  assign ev_ext     = ev_ext_reg;
  assign ev_release = ev_release_reg;
  assign shift_held = shift_l_reg | shift_r_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: byte table plus latency, overflow, long-hold and reset sequences.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       data_valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic [7:0] ev_ascii;
  logic       shift_held;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.SYNC_STAGES(2), .PAUSE_SKIP(7)) dut (
    .clk          (clk),
    .RST          (RST),
    .data_valid_in(data_valid_in),
    .data_in      (data_in),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_release   (ev_release),
    .ev_ascii     (ev_ascii),
    .shift_held   (shift_held),
    .overflow     (overflow)
  );

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
    logic       shift;
  } vec_t;

  ev_t  evq[$];
  vec_t vecs[$];

  // Record every accepted event; ev_ready only changes away from negedge
  always @(negedge clk) begin
    if (RST && ev_valid && ev_ready)
      evq.push_back('{ev_code, ev_ext, ev_release, ev_ascii});
  end

  function automatic logic [7:0] ax(input logic [7:0] v);
`ifdef PS2_ASCII_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    data_in       = b;
    data_valid_in = 1'b1;
    repeat (hold) @(negedge clk);
    data_valid_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic add(input logic [7:0] b, input logic ev, input logic [7:0] code,
                     input logic ext, input logic rel, input logic [7:0] ascii, input logic shift);
    vecs.push_back('{b, ev, code, ext, rel, ascii, shift});
  endtask

  task automatic add_none(input logic [7:0] b, input logic shift);
    add(b, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, shift);
  endtask

  initial begin
    int n0;
    ev_t e;

    add(8'h1C, 1, 8'h1C, 0, 0, ax(8'h61), 0);
    add_none(8'hF0, 0);
    add(8'h1C, 1, 8'h1C, 0, 1, 8'h00, 0);
    add(8'h12, 1, 8'h12, 0, 0, 8'h00, 1);
    add(8'h1C, 1, 8'h1C, 0, 0, ax(8'h41), 1);
    add_none(8'hF0, 1);
    add(8'h12, 1, 8'h12, 0, 1, 8'h00, 0);
    add(8'h1C, 1, 8'h1C, 0, 0, ax(8'h61), 0);
    add_none(8'hE0, 0);
    add(8'h75, 1, 8'h75, 1, 0, 8'h00, 0);
    add_none(8'hE0, 0);
    add_none(8'hF0, 0);
    add(8'h75, 1, 8'h75, 1, 1, 8'h00, 0);
    add_none(8'hE0, 0);
    add_none(8'h12, 0);
    add_none(8'hE0, 0);
    add_none(8'hF0, 0);
    add_none(8'h12, 0);
    add_none(8'hE1, 0);
    add_none(8'h14, 0);
    add_none(8'h77, 0);
    add_none(8'hE1, 0);
    add_none(8'hF0, 0);
    add_none(8'h14, 0);
    add_none(8'hF0, 0);
    add_none(8'h77, 0);
    add(8'h29, 1, 8'h29, 0, 0, ax(8'h20), 0);
    add_none(8'hAA, 0);
    add(8'h45, 1, 8'h45, 0, 0, ax(8'h30), 0);
    add(8'h5A, 1, 8'h5A, 0, 0, ax(8'h0D), 0);
    add_none(8'hE0, 0);
    add_none(8'hE0, 0);
    add(8'h1F, 1, 8'h1F, 1, 0, 8'h00, 0);
    add(8'h59, 1, 8'h59, 0, 0, 8'h00, 1);
    add_none(8'hF0, 1);
    add(8'h59, 1, 8'h59, 0, 1, 8'h00, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ev_valid", 32'(ev_valid), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_shift", 32'(shift_held), 0);
    chk("reset_code", 32'(ev_code), 0);
    RST = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: edge before posedge 1 -> ev_valid after posedge 4
    @(posedge clk); #1;
    data_in = 8'h1C; data_valid_in = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("latency_not_yet", 32'(ev_valid), 0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(ev_valid), 1);
    chk("latency_code", 32'(ev_code), 32'h1C);
    data_valid_in = 1'b0;
    repeat (6) @(negedge clk);

    foreach (vecs[i]) begin
      n0 = evq.size();
      send_byte(vecs[i].b, 4);
      $display("vec %0d: byte %02h events %0d shift %0b", i, vecs[i].b, evq.size() - n0, shift_held);
      chk($sformatf("v%0d_count", i), 32'(evq.size() - n0), 32'(vecs[i].ev));
      chk($sformatf("v%0d_shift", i), 32'(shift_held), 32'(vecs[i].shift));
      if (vecs[i].ev && evq.size() > n0) begin
        e = evq[n0];
        chk($sformatf("v%0d_code", i), 32'(e.code), 32'(vecs[i].code));
        chk($sformatf("v%0d_ext", i), 32'(e.ext), 32'(vecs[i].ext));
        chk($sformatf("v%0d_rel", i), 32'(e.rel), 32'(vecs[i].rel));
        chk($sformatf("v%0d_ascii", i), 32'(e.ascii), 32'(vecs[i].ascii));
      end
    end
    chk("no_overflow_yet", 32'(overflow), 0);

    // Backpressure: second event dropped, first retained
    ev_ready = 1'b0;
    n0 = evq.size();
    send_byte(8'h1C, 4);
    send_byte(8'h32, 4);
    $display("backpressure: valid %0b code %02h overflow %0b", ev_valid, ev_code, overflow);
    chk("bp_valid", 32'(ev_valid), 1);
    chk("bp_code", 32'(ev_code), 32'h1C);
    chk("bp_overflow", 32'(overflow), 1);
    @(posedge clk); #1;
    ev_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_cleared", 32'(ev_valid), 0);
    chk("bp_one_accept", 32'(evq.size() - n0), 1);
    repeat (5) @(negedge clk);
    chk("bp_still_one", 32'(evq.size() - n0), 1);
    chk("bp_overflow_sticky", 32'(overflow), 1);

    // Level held for 500 cycles yields one event
    n0 = evq.size();
    send_byte(8'h1C, 500);
    $display("long hold: events %0d", evq.size() - n0);
    chk("hold_one_event", 32'(evq.size() - n0), 1);

    // Reset mid-prefix
    send_byte(8'hE0, 4);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_code", 32'(ev_code), 0);
    chk("rst_ascii", 32'(ev_ascii), 0);
    chk("rst_ext", 32'(ev_ext), 0);
    RST = 1'b1;
    @(negedge clk);
    n0 = evq.size();
    send_byte(8'h1C, 4);
    $display("after reset: events %0d", evq.size() - n0);
    chk("post_rst_count", 32'(evq.size() - n0), 1);
    if (evq.size() > n0) begin
      chk("post_rst_code", 32'(evq[n0].code), 32'h1C);
      chk("post_rst_ext", 32'(evq[n0].ext), 0);
      chk("post_rst_rel", 32'(evq[n0].rel), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
